// File: rtl/bp_common_pkg.sv
// Shared local-region definitions: configuration selector, responder states,
// scratch/mtime addresses and the byte-mask expansion helper.
package bp_common_pkg;

    typedef enum logic [0:0] {
        e_bp_default_cfg = 1'b0
    } bp_params_e;

    typedef enum logic [0:0] {
        e_ready = 1'b0,
        e_resp  = 1'b1
    } bp_local_resp_state_e;

    localparam logic [39:0] local_scratch_base_gp = 40'h00_0020_0000;
    localparam logic [39:0] local_mtime_addr_gp   = 40'h00_0020_BFF8;

    function automatic int bp_paddr_width(bp_params_e cfg);
        case (cfg)
            e_bp_default_cfg: return 40;
            default:          return 40;
        endcase
    endfunction

    // One mask bit per byte lane becomes eight data bits.
    function automatic logic [63:0] expand_byte_mask(logic [7:0] m);
        logic [63:0] r;
        r = '0;
        for (int b = 0; b < 8; b++) r[8*b +: 8] = {8{m[b]}};
        return r;
    endfunction

endpackage

// File: rtl/bp_local_responder_if.sv
// Uncached command/response channel between the core and the local responder.
interface bp_local_responder_if
    import bp_common_pkg::*;
#(
    parameter int paddr_width_p = bp_paddr_width(e_bp_default_cfg)
);
    logic                     cmd_v_i;
    logic                     cmd_ready_o;
    logic                     cmd_wr_i;
    logic [paddr_width_p-1:0] cmd_addr_i;
    logic [1:0]               cmd_size_i;
    logic [63:0]              cmd_data_i;
    logic                     resp_v_o;
    logic                     resp_yumi_i;
    logic                     resp_wr_o;
    logic                     resp_err_o;
    logic [63:0]              resp_data_o;

    modport slave (
        input  cmd_v_i, cmd_wr_i, cmd_addr_i, cmd_size_i, cmd_data_i, resp_yumi_i,
        output cmd_ready_o, resp_v_o, resp_wr_o, resp_err_o, resp_data_o
    );

    modport master (
        output cmd_v_i, cmd_wr_i, cmd_addr_i, cmd_size_i, cmd_data_i, resp_yumi_i,
        input  cmd_ready_o, resp_v_o, resp_wr_o, resp_err_o, resp_data_o
    );
endinterface

// File: rtl/bp_local_mask_gen.sv
// Byte-lane mask for an access of 2^size bytes starting at lane offset.
module bp_local_mask_gen
    import bp_common_pkg::*;
(
    input  logic [1:0] size,
    input  logic [2:0] offset,
    output logic [7:0] mask
);
    logic [7:0] lanes;

    always_comb begin
        case (size)
            2'd0:    lanes = 8'h01;
            2'd1:    lanes = 8'h03;
            2'd2:    lanes = 8'h0F;
            default: lanes = 8'hFF;
        endcase
        mask = lanes << offset;
    end
endmodule

// File: rtl/bp_local_responder.sv
// Local-region responder: scratch registers plus a free-running mtime counter
// behind a one-deep registered response.
// state   | meaning
// e_ready | accepting a command
// e_resp  | response held until consumed
module bp_local_responder
    import bp_common_pkg::*;
#(
    parameter bp_params_e bp_params_p   = e_bp_default_cfg,
    parameter int         num_scratch_p = 8,
    localparam int        paddr_width_p = bp_paddr_width(bp_params_p)
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    bp_local_responder_if.slave  io
);
    localparam int idx_w = (num_scratch_p > 1) ? $clog2(num_scratch_p) : 1;
    localparam logic [paddr_width_p-4:0] scratch_word_base =
        local_scratch_base_gp[paddr_width_p-1:3];
    localparam logic [paddr_width_p-4:0] mtime_word =
        local_mtime_addr_gp[paddr_width_p-1:3];

    bp_local_resp_state_e state;
    logic [63:0] scratch [num_scratch_p];
    logic [63:0] mtime;
    logic        resp_wr, resp_err;
    logic [63:0] resp_data;

    logic [paddr_width_p-4:0] word, scratch_off;
    logic [idx_w-1:0] scratch_idx;
    logic [2:0]  offset, align_mask;
    logic [3:0]  nbytes;
    logic        scratch_hit, mtime_hit, misaligned, err, handshake, store;
    logic [7:0]  store_mask, load_mask;
    logic [63:0] store_bits, wdata, rdata, load_data;

    bp_local_mask_gen u_store_mask (.size(io.cmd_size_i), .offset(offset), .mask(store_mask));
    bp_local_mask_gen u_load_mask  (.size(io.cmd_size_i), .offset(3'b000), .mask(load_mask));

    always_comb begin
        offset      = io.cmd_addr_i[2:0];
        word        = io.cmd_addr_i[paddr_width_p-1:3];
        scratch_off = word - scratch_word_base;
        scratch_idx = scratch_off[idx_w-1:0];
        scratch_hit = scratch_off < (paddr_width_p-3)'(num_scratch_p);
        mtime_hit   = (word == mtime_word);
        nbytes      = 4'd1 << io.cmd_size_i;
        align_mask  = 3'(nbytes - 4'd1);
        misaligned  = |(offset & align_mask);
        err         = ~(scratch_hit | mtime_hit) | misaligned;
        handshake   = io.cmd_v_i & (state == e_ready);
        store       = handshake & io.cmd_wr_i & ~err;
        store_bits  = expand_byte_mask(store_mask);
        wdata       = io.cmd_data_i << {offset, 3'b000};
        rdata       = mtime_hit ? mtime : scratch[scratch_idx];
        load_data   = (rdata >> {offset, 3'b000}) & expand_byte_mask(load_mask);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state     <= e_ready;
            resp_wr   <= 1'b0;
            resp_err  <= 1'b0;
            resp_data <= '0;
        end else begin
            case (state)
                e_ready: if (io.cmd_v_i) begin
                    state     <= e_resp;
                    resp_wr   <= io.cmd_wr_i;
                    resp_err  <= err;
                    resp_data <= (io.cmd_wr_i | err) ? 64'd0 : load_data;
                end
                default: if (io.resp_yumi_i) state <= e_ready;
            endcase
        end
    end

    // A store to mtime replaces that cycle's increment.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
            mtime <= '0;
        else if (store && mtime_hit)
            mtime <= (mtime & ~store_bits) | (wdata & store_bits);
        else
            mtime <= mtime + 64'd1;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < num_scratch_p; i++) scratch[i] <= '0;
        end else if (store && scratch_hit) begin
            for (int i = 0; i < num_scratch_p; i++)
                if (i == int'(scratch_idx))
                    scratch[i] <= (scratch[i] & ~store_bits) | (wdata & store_bits);
        end
    end

    assign io.cmd_ready_o = (state == e_ready);
    assign io.resp_v_o    = (state == e_resp);
    assign io.resp_wr_o   = resp_wr;
    assign io.resp_err_o  = resp_err;
    assign io.resp_data_o = resp_data;
endmodule

// File: tb/tb_bp_local_responder.sv
// Self-checking bench for bp_local_responder: directed scenarios plus random
// traffic against a byte-level reference model with a cycle-based mtime.
module tb_bp_local_responder;
    localparam logic [39:0] scr_base = 40'h0020_0000;
    localparam logic [39:0] mt_addr  = 40'h0020_BFF8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   ecount;

    logic [63:0] mdl_scr [8];
    logic [63:0] mt_base;
    int          mt_edge;
    logic [63:0] obs;

    always #5 clk = ~clk;

    bp_local_responder_if #(.paddr_width_p(40)) bus ();

    bp_local_responder dut (
        .clk_i     (clk),
        .reset_n_i (rst_n),
        .io        (bus)
    );

    always @(posedge clk or negedge rst_n)
        if (!rst_n) ecount <= 0;
        else        ecount <= ecount + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got=%h want=%h", tag, got, want);
        end
    endtask

    // mtime as seen in the current cycle: last written value plus elapsed edges.
    function automatic logic [63:0] mt_now();
        return mt_base + 64'(ecount - mt_edge);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mdl_scr[i] = '0;
        mt_base = '0;
        mt_edge = 0;
    endtask

    // Called at a negedge with the bus idle; returns the observed response data.
    task automatic issue(input logic wr, input logic [39:0] addr, input logic [1:0] size,
                         input logic [63:0] data, input int hold, output logic [63:0] got);
        int nb, off, idx;
        logic is_mt, is_scr, exp_err;
        logic [63:0] cur, nv, exp_data;
        nb = 1 << size;
        off = int'(addr[2:0]);
        is_mt = (addr >> 3) == (mt_addr >> 3);
        is_scr = (addr >= scr_base) && (addr < scr_base + 40'd64);
        idx = is_scr ? int'((addr - scr_base) >> 3) : 0;
        exp_err = (!is_mt && !is_scr) || (off % nb != 0);
        exp_data = '0;
        if (!exp_err) begin
            cur = is_mt ? mt_now() : mdl_scr[idx];
            if (wr) begin
                nv = cur;
                for (int b = 0; b < nb; b++) nv[8*(off+b) +: 8] = data[8*b +: 8];
                if (is_mt) begin
                    mt_base = nv;
                    mt_edge = ecount + 1;
                end else mdl_scr[idx] = nv;
            end else begin
                for (int b = 0; b < nb; b++) exp_data[8*b +: 8] = cur[8*(off+b) +: 8];
            end
        end
        bus.cmd_v_i = 1'b1;
        bus.cmd_wr_i = wr;
        bus.cmd_addr_i = addr;
        bus.cmd_size_i = size;
        bus.cmd_data_i = data;
        chk("cmd_ready_idle", 64'(bus.cmd_ready_o), 64'd1);
        @(negedge clk);
        chk("resp_v_latency", 64'(bus.resp_v_o), 64'd1);
        chk("resp_err", 64'(bus.resp_err_o), 64'(exp_err));
        chk("resp_wr", 64'(bus.resp_wr_o), 64'(wr));
        chk("resp_data", bus.resp_data_o, exp_data);
        got = bus.resp_data_o;
        bus.cmd_v_i = (hold > 0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_ready", 64'(bus.cmd_ready_o), 64'd0);
            chk("hold_resp_v", 64'(bus.resp_v_o), 64'd1);
            chk("hold_data", bus.resp_data_o, exp_data);
            chk("hold_err", 64'(bus.resp_err_o), 64'(exp_err));
        end
        bus.cmd_v_i = 1'b0;
        bus.resp_yumi_i = 1'b1;
        @(negedge clk);
        bus.resp_yumi_i = 1'b0;
        chk("post_yumi_resp_v", 64'(bus.resp_v_o), 64'd0);
        chk("post_yumi_ready", 64'(bus.cmd_ready_o), 64'd1);
    endtask

    initial begin
        logic [39:0] a;
        logic [1:0]  sz;
        int          sel, nb;
        bus.cmd_v_i = 1'b0;
        bus.cmd_wr_i = 1'b0;
        bus.cmd_addr_i = '0;
        bus.cmd_size_i = '0;
        bus.cmd_data_i = '0;
        bus.resp_yumi_i = 1'b0;
        model_reset();

        #12;
        chk("rst_ready", 64'(bus.cmd_ready_o), 64'd1);
        chk("rst_resp_v", 64'(bus.resp_v_o), 64'd0);
        chk("rst_resp_data", bus.resp_data_o, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(1'b0, mt_addr, 2'd3, '0, 0, obs);
        issue(1'b0, scr_base + 40'h38, 2'd3, '0, 0, obs);
        chk("reset_scratch7", obs, 64'd0);

        issue(1'b1, scr_base + 40'h8, 2'd3, 64'hDEAD_BEEF_0123_4567, 0, obs);
        issue(1'b0, scr_base + 40'h8, 2'd3, '0, 0, obs);
        chk("full_word_rt", obs, 64'hDEAD_BEEF_0123_4567);

        issue(1'b1, scr_base + 40'h3, 2'd0, 64'hAB, 0, obs);
        issue(1'b0, scr_base, 2'd3, '0, 0, obs);
        chk("byte_lane3", obs, 64'h0000_0000_AB00_0000);

        issue(1'b0, 40'h00_8000_0000, 2'd3, '0, 0, obs);
        issue(1'b0, scr_base + 40'h1, 2'd1, '0, 0, obs);
        issue(1'b1, 40'h10_0020_0000, 2'd3, 64'h1234, 0, obs);
        issue(1'b1, scr_base + 40'h40, 2'd3, 64'h5678, 0, obs);
        issue(1'b1, scr_base + 40'hC, 2'd3, 64'h9ABC, 0, obs);
        issue(1'b0, scr_base, 2'd3, '0, 0, obs);
        chk("err_no_change", obs, 64'h0000_0000_AB00_0000);

        issue(1'b1, mt_addr, 2'd3, 64'hFFFF_FFFF_FFFF_FFFE, 0, obs);
        repeat (2) @(negedge clk);
        issue(1'b0, mt_addr, 2'd3, '0, 0, obs);
        chk("mtime_wrap", obs, 64'h1);
        issue(1'b1, mt_addr + 40'h4, 2'd2, 64'h0000_0007, 0, obs);
        issue(1'b0, mt_addr + 40'h4, 2'd2, '0, 0, obs);

        issue(1'b0, scr_base + 40'h8, 2'd2, '0, 5, obs);
        issue(1'b0, scr_base + 40'hC, 2'd2, '0, 0, obs);
        chk("upper_half", obs, 64'hDEAD_BEEF);

        for (int n = 0; n < 200; n++) begin
            sz = 2'($urandom_range(0, 3));
            nb = 1 << sz;
            sel = $urandom_range(0, 99);
            a = scr_base + 40'(8 * $urandom_range(0, 7)) + 40'($urandom_range(0, 7) & ~(nb - 1));
            if (sel >= 70 && sel < 80) a = mt_addr + 40'($urandom_range(0, 7) & ~(nb - 1));
            else if (sel >= 80 && sel < 88) a = scr_base + 40'($urandom_range(0, 63));
            else if (sel >= 88 && sel < 92) a = scr_base + 40'h40 + 40'($urandom_range(0, 7) & ~(nb - 1));
            else if (sel >= 92 && sel < 96) a = scr_base - 40'd8;
            else if (sel >= 96) a = {8'($urandom_range(1, 255)), 32'h0020_0000};
            issue(1'(($urandom & 2) != 0), a, sz, {$urandom, $urandom},
                  ($urandom_range(0, 9) == 0) ? 2 : 0, obs);
        end

        issue(1'b1, scr_base, 2'd3, 64'h1111_2222_3333_4444, 0, obs);
        bus.cmd_v_i = 1'b1;
        bus.cmd_wr_i = 1'b0;
        bus.cmd_addr_i = scr_base;
        bus.cmd_size_i = 2'd3;
        @(negedge clk);
        bus.cmd_v_i = 1'b0;
        chk("pre_reset_resp_v", 64'(bus.resp_v_o), 64'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_resp_v", 64'(bus.resp_v_o), 64'd0);
        chk("async_rst_ready", 64'(bus.cmd_ready_o), 64'd1);
        chk("async_rst_data", bus.resp_data_o, 64'd0);
        model_reset();
        repeat (2) @(negedge clk);
        chk("held_rst_ready", 64'(bus.cmd_ready_o), 64'd1);
        rst_n = 1'b1;
        issue(1'b0, scr_base, 2'd3, '0, 0, obs);
        chk("post_rst_reg0", obs, 64'd0);
        issue(1'b0, mt_addr, 2'd3, '0, 0, obs);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
